// File: rtl/i2c_target_regfile.sv
// I2C target with a small byte-addressed register file. Both bus lines are
// oversampled on clk; writes auto-increment the pointer, reads stream from it.
module i2c_target_regfile #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned PTR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oen,
  output logic             busy,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] loc_addr,
  output logic [7:0]       loc_data
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } state_e;

  logic scl_ff1_q, scl_ff2_q, scl_hist_q;
  logic sda_ff1_q, sda_ff2_q, sda_hist_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0]  shift_q, shift_d;
  logic [BYTE_W-2:0]  rd_byte_q, rd_byte_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               rw_q, rw_d;
  logic               phase_q, phase_d;
  logic               sda_oen_q, sda_oen_d;
  logic               busy_q, busy_d;
  logic               wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]  wr_data_q, wr_data_d;
  logic [BYTE_W-1:0]  mem_q [MEM_DEPTH];

  logic               scl_rise_c, scl_fall_c, sda_rise_c, sda_fall_c;
  logic               start_c, stop_c, mem_we_c;
  logic [BYTE_W-1:0]  byte_c, rd_word_c;

  // Two-flop synchronizers plus a history flop; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_ff1_q  <= 1'b1;
      scl_ff2_q  <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_ff1_q  <= 1'b1;
      sda_ff2_q  <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_ff1_q  <= scl_i;
      scl_ff2_q  <= scl_ff1_q;
      scl_hist_q <= scl_ff2_q;
      sda_ff1_q  <= sda_i;
      sda_ff2_q  <= sda_ff1_q;
      sda_hist_q <= sda_ff2_q;
    end
  end

  assign scl_rise_c = scl_ff2_q & ~scl_hist_q;
  assign scl_fall_c = ~scl_ff2_q & scl_hist_q;
  assign sda_rise_c = sda_ff2_q & ~sda_hist_q;
  assign sda_fall_c = ~sda_ff2_q & sda_hist_q;
  assign start_c    = sda_fall_c & scl_ff2_q & scl_hist_q;
  assign stop_c     = sda_rise_c & scl_ff2_q & scl_hist_q;
  assign byte_c     = {shift_q, sda_ff2_q};
  assign rd_word_c  = mem_q[ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rd_byte_q  <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      sda_oen_q  <= 1'b1;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rd_byte_q  <= rd_byte_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      sda_oen_q  <= sda_oen_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      mem_q[ptr_q] <= byte_c;
    end
  end

  // Next-state logic; START/STOP override whatever byte is in progress.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rd_byte_d  = rd_byte_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    sda_oen_d  = sda_oen_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we_c   = 1'b0;

    if (stop_c) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      sda_oen_d = 1'b1;
      phase_d   = 1'b0;
      bit_cnt_d = '0;
    end else if (start_c) begin
      state_d   = S_ADDR;
      sda_oen_d = 1'b1;
      phase_d   = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_oen_d = 1'b1;
        end

        S_ADDR: begin
          if (scl_rise_c) begin
            shift_d   = byte_c[BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              if (byte_c[7:1] == TARGET_ADDR) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_c[0];
              end else begin
                state_d = S_WAIT_STOP;
              end
            end
          end
        end

        S_PTR: begin
          if (scl_rise_c) begin
            shift_d   = byte_c[BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              ptr_d     = byte_c[PTR_W-1:0];
              state_d   = S_PTR_ACK;
            end
          end
        end

        S_WDATA: begin
          if (scl_rise_c) begin
            shift_d   = byte_c[BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d  = '0;
              mem_we_c   = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_c;
              ptr_d      = ptr_q + PTR_W'(1);
              state_d    = S_WDATA_ACK;
            end
          end
        end

        // Phase 0 waits for the fall that starts the ACK slot, phase 1 for the one that ends it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall_c) begin
            if (!phase_q) begin
              sda_oen_d = 1'b0;
              phase_d   = 1'b1;
            end else begin
              phase_d   = 1'b0;
              sda_oen_d = 1'b1;
              bit_cnt_d = '0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_d   = S_RDATA;
                rd_byte_d = rd_word_c[BYTE_W-2:0];
                sda_oen_d = rd_word_c[BYTE_W-1];
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end

        // Remaining bits of the latched byte are shifted out on each SCL fall.
        S_RDATA: begin
          if (scl_fall_c) begin
            if (bit_cnt_q == CNT_W'(7)) begin
              sda_oen_d = 1'b1;
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              state_d   = S_RDATA_ACK;
            end else begin
              sda_oen_d = rd_byte_q[BYTE_W-2];
              rd_byte_d = {rd_byte_q[BYTE_W-3:0], 1'b0};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end

        S_RDATA_ACK: begin
          if (!phase_q) begin
            if (scl_rise_c) begin
              ptr_d = ptr_q + PTR_W'(1);
              if (sda_ff2_q) begin
                state_d = S_WAIT_STOP;
              end else begin
                phase_d = 1'b1;
              end
            end
          end else if (scl_fall_c) begin
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            rd_byte_d = rd_word_c[BYTE_W-2:0];
            sda_oen_d = rd_word_c[BYTE_W-1];
            state_d   = S_RDATA;
          end
        end

        S_WAIT_STOP: begin
          sda_oen_d = 1'b1;
        end

        default: begin
          state_d   = S_IDLE;
          sda_oen_d = 1'b1;
        end
      endcase
    end
  end

  assign sda_oen  = sda_oen_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign loc_data = mem_q[loc_addr];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, transaction-level register
// file model, and a scoreboard monitor for bus responses and write strobes.
module tb_i2c_target_regfile;

  localparam logic [6:0] TGT   = 7'h50;
  localparam int         DEPTH = 16;
  localparam int         PW    = 4;
  localparam int         Q     = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          scl;
  logic          m_sda;
  logic          sda_line;
  logic          sda_oen;
  logic          busy;
  logic          wr_valid;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [PW-1:0] loc_addr;
  logic [7:0]    loc_data;

  always #5 clk = ~clk;

  // Open-drain bus with pull-up: either side may pull low.
  assign sda_line = m_sda & sda_oen;

  i2c_target_regfile #(
    .TARGET_ADDR(TGT),
    .MEM_DEPTH  (DEPTH),
    .PTR_W      (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl),
    .sda_i   (sda_line),
    .sda_oen (sda_oen),
    .busy    (busy),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .loc_addr(loc_addr),
    .loc_data(loc_data)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  m_mem [DEPTH];
  int          m_ptr;
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_bus_q[$];
  string       exp_name_q[$];
  logic [7:0]  obs_q[$];
  logic [11:0] exp_wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_bus(input string name, input logic [7:0] v);
    exp_name_q.push_back(name);
    exp_bus_q.push_back(v);
  endtask

  task automatic check_loc(input int i);
    loc_addr = PW'(i);
    #1;
    check($sformatf("loc_data[%0d]", i), 32'(loc_data), 32'(m_mem[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    #(Q); scl = 1'b1;
    #(2*Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); b = sda_line;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); m_sda = 1'b0;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); m_sda = 1'b1;
    #(Q);
    check("busy_after_stop", 32'(busy), 32'd0);
    check("sda_released_after_stop", 32'(sda_oen), 32'd1);
  endtask

  // Observed ACK is recorded as 1 when the target pulled SDA low.
  task automatic write_byte(input logic [7:0] b);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    obs_q.push_back({7'd0, ~a});
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] v;
    for (int i = 7; i >= 0; i--) recv_bit(v[i]);
    obs_q.push_back(v);
    send_bit(nack);
  endtask

  task automatic m_write(input logic [7:0] abyte, input logic [7:0] pbyte, input int n, input bit do_stop);
    bit hit;
    hit = (abyte[7:1] == TGT);
    i2c_start();
    expect_bus("addr_ack", {7'd0, hit});
    write_byte(abyte);
    check("busy_after_addr", 32'(busy), 32'(hit));
    if (hit) begin
      expect_bus("ptr_ack", 8'd1);
      write_byte(pbyte);
      m_ptr = int'(pbyte) % DEPTH;
      for (int i = 0; i < n; i++) begin
        expect_bus("wdata_ack", 8'd1);
        exp_wr_q.push_back({PW'(m_ptr), tx_q[i]});
        m_mem[m_ptr] = tx_q[i];
        m_ptr = (m_ptr + 1) % DEPTH;
        write_byte(tx_q[i]);
      end
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic m_read(input int n);
    i2c_start();
    expect_bus("raddr_ack", 8'd1);
    write_byte({TGT, 1'b1});
    check("busy_in_read", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      expect_bus("rd_byte", m_mem[m_ptr]);
      m_ptr = (m_ptr + 1) % DEPTH;
      read_byte(i == n - 1);
    end
    i2c_stop();
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents a response.
  initial begin
    logic [11:0] e;
    logic [7:0]  o;
    forever begin
      @(negedge clk);
      if (!rst && wr_valid) begin
        if (exp_wr_q.size() == 0) begin
          check("wr_valid_unexpected", 32'(wr_valid), 32'd0);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[11:8]));
          check("wr_data", 32'(wr_data), 32'(e[7:0]));
        end
      end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_bus_q.size() == 0) begin
          check("bus_unexpected_obs", 32'(o), 32'hFFFF_FFFF);
        end else begin
          check(exp_name_q.pop_front(), 32'(o), 32'(exp_bus_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n;
    logic [7:0] a;
    rst      = 1'b1;
    scl      = 1'b1;
    m_sda    = 1'b1;
    loc_addr = '0;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_sda_oen", 32'(sda_oen), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic write with auto-increment.
    tx_q = '{8'h11, 8'h22};
    m_write(8'hA0, 8'h03, 2, 1'b1);
    check_loc(3);
    check_loc(4);

    // Pointer write, repeated start, read back; then continue from the advanced pointer.
    m_write(8'hA0, 8'h03, 0, 1'b0);
    m_read(2);
    m_read(1);

    // Wrong address and general call are not acknowledged; target then ignores bytes.
    i2c_start();
    expect_bus("miss_addr_ack", 8'd0);
    write_byte(8'hA2);
    check("busy_after_miss", 32'(busy), 32'd0);
    expect_bus("wait_stop_ack", 8'd0);
    write_byte(8'h00);
    i2c_stop();
    i2c_start();
    expect_bus("gcall_ack", 8'd0);
    write_byte(8'h00);
    i2c_stop();

    // Pointer wrap at the top of the register file.
    tx_q = '{8'hAA, 8'hBB};
    m_write(8'hA0, 8'h0F, 2, 1'b1);
    check_loc(15);
    check_loc(0);
    m_write(8'hA0, 8'h0F, 0, 1'b0);
    m_read(2);

    // STOP after four data bits aborts the byte; next transaction behaves normally.
    m_write(8'hA0, 8'h07, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    i2c_stop();
    m_read(1);
    check_loc(7);

    // Reset while the target drives a 0 read bit.
    tx_q = '{8'h5A};
    m_write(8'hA0, 8'h09, 1, 1'b1);
    m_write(8'hA0, 8'h09, 0, 1'b0);
    i2c_start();
    expect_bus("rst_read_addr_ack", 8'd1);
    write_byte({TGT, 1'b1});
    repeat (2) @(negedge clk);
    check("read_bit_driven", 32'(sda_oen), 32'(m_mem[9][7]));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("sda_oen_after_rst", 32'(sda_oen), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    i2c_stop();
    for (int i = 0; i < DEPTH; i++) check_loc(i);

    // Randomized traffic against the model.
    for (int t = 0; t < 10; t++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      case (kind)
        0: begin
          tx_q.delete();
          for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
          m_write(8'hA0, 8'($urandom), n, 1'b1);
        end
        1: begin
          m_write(8'hA0, 8'($urandom), 0, 1'b0);
          m_read(n);
        end
        2: m_read(n);
        default: begin
          a = {7'($urandom), 1'($urandom)};
          if (a[7:1] == TGT) a = 8'h00;
          i2c_start();
          expect_bus("rand_miss_ack", 8'd0);
          write_byte(a);
          i2c_stop();
        end
      endcase
    end
    for (int i = 0; i < DEPTH; i++) check_loc(i);

    repeat (20) @(negedge clk);
    check("bus_exp_drained", 32'(exp_bus_q.size()), 32'd0);
    check("wr_exp_drained", 32'(exp_wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
